// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the integer multiply/divide unit.
// Holds the operand width, the function-select encodings shared with the
// single-cycle ALU, and the multiply/divide sequencer state encoding.
package mult_div_unit_pkg;

   localparam int WIDTH = 32;

   // The single-cycle ALU owns function selects 5'h00..5'h19.
   localparam logic [4:0] FS_ALU_FIRST = 5'h00;
   localparam logic [4:0] FS_ALU_LAST  = 5'h19;

   // Function selects handled by the multi-cycle unit.
   localparam logic [4:0] FS_MULT  = 5'h1A;
   localparam logic [4:0] FS_MULTU = 5'h1B;
   localparam logic [4:0] FS_DIV   = 5'h1C;
   localparam logic [4:0] FS_DIVU  = 5'h1D;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/mult_div_unit_negate.sv
// Parameterised conditional two's-complement negate.
// Ports:
//   a    in  W  value
//   neg  in  1  1 = output -a, 0 = output a unchanged
//   y    out W  result
module mult_div_unit_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Operands are reduced to unsigned magnitudes on acceptance, iterated
// WIDTH times (shift-add multiply or restoring divide), then the result
// halves are sign-corrected and registered together with the flags.
// Ports:
//   clk    in   1      system clock, rising edge
//   reset  in   1      synchronous active-high reset
//   start  in   1      request, honoured only in IDLE with FS in 1A..1D
//   FS     in   5      function select
//   S, T   in   WIDTH  operands (multiplicand/dividend, multiplier/divisor)
//   busy   out  1      operation in flight
//   done   out  1      one-cycle pulse, result valid from this cycle
//   Y_hi   out  WIDTH  product high half / remainder
//   Y_lo   out  WIDTH  product low half / quotient
//   N Z V C out 1      flags (C always 0)
//
// state | meaning
// IDLE  | waiting for start with a multiply/divide function select
// CALC  | one multiply or divide iteration per cycle, WIDTH iterations
// SIGN  | sign-correct result halves, register result and flags
// DONE  | done pulse for one cycle, then back to IDLE
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = mult_div_unit_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       FS,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] T,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y_hi,
   output logic [WIDTH-1:0] Y_lo,
   output logic             N,
   output logic             Z,
   output logic             V,
   output logic             C
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   md_state_t state, state_nxt;

   logic               op_div;
   logic               op_signed;
   logic               sign_q;
   logic               sign_r;
   logic               div0;
   logic               ovf;
   logic [WIDTH-1:0]   opa;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic fs_ok, is_div_in, is_signed_in, accept, load_res;

   assign fs_ok        = (FS == FS_MULT) || (FS == FS_MULTU) ||
                         (FS == FS_DIV)  || (FS == FS_DIVU);
   assign is_div_in    = (FS == FS_DIV)  || (FS == FS_DIVU);
   assign is_signed_in = (FS == FS_MULT) || (FS == FS_DIV);
   assign accept       = (state == ST_IDLE) && start && fs_ok;

   logic [WIDTH-1:0] s_mag, t_mag;

   mult_div_unit_negate #(.W(WIDTH)) u_neg_s (
      .a   (S),
      .neg (is_signed_in & S[WIDTH-1]),
      .y   (s_mag)
   );

   mult_div_unit_negate #(.W(WIDTH)) u_neg_t (
      .a   (T),
      .neg (is_signed_in & T[WIDTH-1]),
      .y   (t_mag)
   );

   // Multiply: acc = {partial product, remaining multiplier bits}; the
   // multiplier is consumed LSB-first from acc[0] as acc shifts right.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_mul_nxt;

   assign mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                        {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
   assign acc_mul_nxt = {mul_sum, acc[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend/quotient}; the dividend
   // leaves from the top of the low half while quotient bits enter at
   // the bottom. The shifted remainder needs WIDTH+1 bits.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ge;
   logic [WIDTH:0]     div_rem_unused_msb;
   logic [2*WIDTH-1:0] acc_div_nxt;

   assign div_shift          = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff           = {1'b0, div_shift} - {2'b00, opa};
   assign div_ge             = ~div_diff[WIDTH+1];
   assign div_rem_unused_msb = div_ge ? div_diff[WIDTH:0] : div_shift;
   assign acc_div_nxt        = {div_rem_unused_msb[WIDTH-1:0],
                                acc[WIDTH-2:0], div_ge};

   // Sign correction. On divide-by-zero the remainder output is the raw
   // dividend, recovered by re-applying its sign to the latched magnitude.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, rem_src;

   assign rem_src = div0 ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];

   mult_div_unit_negate #(.W(2*WIDTH)) u_neg_prod (
      .a   (acc),
      .neg (sign_q),
      .y   (prod_fix)
   );

   mult_div_unit_negate #(.W(WIDTH)) u_neg_quo (
      .a   (acc[WIDTH-1:0]),
      .neg (sign_q),
      .y   (quo_fix)
   );

   mult_div_unit_negate #(.W(WIDTH)) u_neg_rem (
      .a   (rem_src),
      .neg (sign_r),
      .y   (rem_fix)
   );

   logic [WIDTH-1:0] res_hi, res_lo;
   logic             res_n, res_z, res_v;

   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      res_n  = op_signed & prod_fix[2*WIDTH-1];
      res_z  = (prod_fix == '0);
      res_v  = 1'b0;
      if (op_div) begin
         res_hi = rem_fix;
         res_lo = div0 ? {WIDTH{1'b1}} : quo_fix;
         res_n  = op_signed & res_lo[WIDTH-1];
         res_z  = (res_lo == '0);
         res_v  = div0 | ovf;
      end
   end

   always_comb begin
      state_nxt = state;
      load_res  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_CALC;
         end
         ST_CALC: begin
            if (div0) begin
               state_nxt = ST_DONE;
               load_res  = 1'b1;
            end else if (cnt == CNT_W'(1)) begin
               state_nxt = ST_SIGN;
            end
         end
         ST_SIGN: begin
            state_nxt = ST_DONE;
            load_res  = 1'b1;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_CALC) || (state == ST_SIGN);
   assign done = (state == ST_DONE);
   assign C    = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_div    <= 1'b0;
         op_signed <= 1'b0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         div0      <= 1'b0;
         ovf       <= 1'b0;
         opa       <= '0;
         acc       <= '0;
         cnt       <= '0;
         Y_hi      <= '0;
         Y_lo      <= '0;
         N         <= 1'b0;
         Z         <= 1'b0;
         V         <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_div    <= is_div_in;
            op_signed <= is_signed_in;
            sign_q    <= is_signed_in & (S[WIDTH-1] ^ T[WIDTH-1]);
            sign_r    <= is_signed_in & S[WIDTH-1];
            div0      <= is_div_in && (T == '0);
            ovf       <= (FS == FS_DIV) &&
                         (S == {1'b1, {(WIDTH-1){1'b0}}}) &&
                         (T == {WIDTH{1'b1}});
            opa       <= is_div_in ? t_mag : s_mag;
            acc       <= {{WIDTH{1'b0}}, (is_div_in ? s_mag : t_mag)};
            cnt       <= CNT_W'(WIDTH);
         end else if ((state == ST_CALC) && !div0) begin
            acc <= op_div ? acc_div_nxt : acc_mul_nxt;
            cnt <= cnt - CNT_W'(1);
         end
         if (load_res) begin
            Y_hi <= res_hi;
            Y_lo <= res_lo;
            N    <= res_n;
            Z    <= res_z;
            V    <= res_v;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes arithmetic
// expectations, a negedge monitor pops and compares on every done.
module tb_mult_div_unit;

   localparam logic [4:0] OP_MULT  = 5'h1A;
   localparam logic [4:0] OP_MULTU = 5'h1B;
   localparam logic [4:0] OP_DIV   = 5'h1C;
   localparam logic [4:0] OP_DIVU  = 5'h1D;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  FS = 5'h00;
   logic [31:0] S = '0;
   logic [31:0] T = '0;
   logic        busy, done, N, Z, V, C;
   logic [31:0] Y_hi, Y_lo;

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .FS    (FS),
      .S     (S),
      .T     (T),
      .busy  (busy),
      .done  (done),
      .Y_hi  (Y_hi),
      .Y_lo  (Y_lo),
      .N     (N),
      .Z     (Z),
      .V     (V),
      .C     (C)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        n;
      logic        z;
      logic        v;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   exp_t hold;
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   logic rst_q = 1'b1;
   logic prev_done = 1'b0;

   function automatic void report(input bit ok, input string name, input string msg);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: %s", name, msg);
      end
   endfunction

   // Reference model: plain signed/unsigned arithmetic on wide integers.
   function automatic exp_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
      exp_t        r;
      longint      a, b, p, q, m;
      logic [63:0] w;
      a = longint'($signed(s));
      b = longint'($signed(t));
      r.v = 1'b0;
      r.acc = 0;
      r.lat = 33;
      case (fs)
         OP_MULT: begin
            p = a * b;
            w = p;
            r.hi = w[63:32];
            r.lo = w[31:0];
            r.n = w[63];
            r.z = (w == 64'd0);
         end
         OP_MULTU: begin
            w = {32'd0, s} * {32'd0, t};
            r.hi = w[63:32];
            r.lo = w[31:0];
            r.n = 1'b0;
            r.z = (w == 64'd0);
         end
         default: begin
            if (t == 32'd0) begin
               r.hi = s;
               r.lo = 32'hFFFF_FFFF;
               r.v = 1'b1;
               r.lat = 1;
            end else if (fs == OP_DIV) begin
               q = a / b;
               m = a % b;
               w = q;
               r.lo = w[31:0];
               w = m;
               r.hi = w[31:0];
               r.v = (s == 32'h8000_0000) && (t == 32'hFFFF_FFFF);
            end else begin
               r.lo = s / t;
               r.hi = s % t;
            end
            r.n = (fs == OP_DIV) ? r.lo[31] : 1'b0;
            r.z = (r.lo == 32'd0);
         end
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Monitor: reset state, result/latency on done, hold between dones.
   always @(negedge clk) begin
      if (rst_q) begin
         report(busy === 1'b0 && done === 1'b0 && Y_hi === 32'd0 && Y_lo === 32'd0 && {N, Z, V, C} === 4'b0000,
                "reset_state", $sformatf("got busy=%b done=%b hi=%h lo=%h nzvc=%b, required all zero", busy, done, Y_hi, Y_lo, {N, Z, V, C}));
         hold = '{hi: 32'd0, lo: 32'd0, n: 1'b0, z: 1'b0, v: 1'b0, acc: 0, lat: 0};
         prev_done = 1'b0;
      end else begin
         if (done === 1'b1) begin
            report(busy === 1'b0 && !prev_done, "done_pulse",
                   $sformatf("got busy=%b prev_done=%b, required busy=0 prev_done=0", busy, prev_done));
            if (sbq.size() == 0) begin
               report(1'b0, "unexpected_done", $sformatf("got done at cycle %0d, required no done (queue empty)", cyc));
            end else begin
               e = sbq.pop_front();
               report(Y_hi === e.hi && Y_lo === e.lo && {N, Z, V, C} === {e.n, e.z, e.v, 1'b0}, "result",
                      $sformatf("got hi=%h lo=%h nzvc=%b, required hi=%h lo=%h nzvc=%b",
                                Y_hi, Y_lo, {N, Z, V, C}, e.hi, e.lo, {e.n, e.z, e.v, 1'b0}));
               report(cyc - e.acc == e.lat, "latency",
                      $sformatf("got %0d edges accept->done, required %0d", cyc - e.acc, e.lat));
               hold = e;
            end
            done_cnt++;
         end else begin
            report(Y_hi === hold.hi && Y_lo === hold.lo && {N, Z, V, C} === {hold.n, hold.z, hold.v, 1'b0}, "hold",
                   $sformatf("got hi=%h lo=%h nzvc=%b, required hi=%h lo=%h nzvc=%b at cycle %0d",
                             Y_hi, Y_lo, {N, Z, V, C}, hold.hi, hold.lo, {hold.n, hold.z, hold.v, 1'b0}, cyc));
         end
         prev_done = done;
      end
   end

   task automatic push_exp(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t, input int acc);
      exp_t x;
      x = model(fs, s, t);
      x.acc = acc;
      sbq.push_back(x);
   endtask

   task automatic scramble();
      FS = 5'($urandom);
      S = $urandom;
      T = $urandom;
   endtask

   task automatic wait_done(input int target, input int budget);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt >= target) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      report(got, "timeout", $sformatf("got %0d dones, required %0d within %0d cycles", done_cnt, target, budget));
   endtask

   task automatic issue(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
      int sc;
      @(negedge clk);
      start = 1'b1;
      FS = fs;
      S = s;
      T = t;
      sc = done_cnt;
      push_exp(fs, s, t, cyc + 1);
      @(negedge clk);
      start = 1'b0;
      scramble();
      wait_done(sc + 1, 100);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sc, acc;
      logic [4:0]  fsr;
      logic [31:0] sr, tr;
      logic [4:0]  b2b_fs [3];
      logic [31:0] b2b_s [3];
      logic [31:0] b2b_t [3];

      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Directed arithmetic cases.
      issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(OP_MULT, 32'd0, 32'h1234_5678);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      issue(OP_DIVU, 32'd100, 32'd7);
      issue(OP_DIVU, 32'h64, 32'd0);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(OP_DIV, 32'hFFFF_FF00, 32'd0);

      // Non multiply/divide function selects must be ignored.
      @(negedge clk);
      start = 1'b1;
      FS = 5'h02;
      S = $urandom;
      T = $urandom;
      @(negedge clk);
      FS = 5'h1E;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         report(busy === 1'b0, "bad_fs_busy", $sformatf("got busy=%b, required 0", busy));
      end

      // Second start while busy is ignored.
      @(negedge clk);
      start = 1'b1;
      FS = OP_MULT;
      S = 32'hDEAD_BEEF;
      T = 32'h0000_1234;
      sc = done_cnt;
      push_exp(OP_MULT, 32'hDEAD_BEEF, 32'h0000_1234, cyc + 1);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      FS = OP_DIVU;
      S = $urandom;
      T = $urandom;
      @(negedge clk);
      start = 1'b0;
      wait_done(sc + 1, 100);
      repeat (3) @(negedge clk);

      // Reset mid-operation aborts with no done pulse.
      @(negedge clk);
      start = 1'b1;
      FS = OP_MULTU;
      S = $urandom;
      T = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      report(busy === 1'b0 && done === 1'b0 && Y_hi === 32'd0 && Y_lo === 32'd0 && {N, Z, V, C} === 4'b0000,
             "reset_abort", $sformatf("got busy=%b done=%b hi=%h lo=%h nzvc=%b, required all zero", busy, done, Y_hi, Y_lo, {N, Z, V, C}));
      repeat (45) @(negedge clk);

      // Back-to-back with start held high: one accept every 35 edges.
      b2b_fs[0] = OP_MULT;  b2b_s[0] = 32'hFFFF_0001; b2b_t[0] = 32'h0001_0003;
      b2b_fs[1] = OP_DIV;   b2b_s[1] = 32'h7654_3210; b2b_t[1] = 32'hFFFF_FFF3;
      b2b_fs[2] = OP_MULTU; b2b_s[2] = 32'h8000_0001; b2b_t[2] = 32'h0000_0010;
      @(negedge clk);
      start = 1'b1;
      FS = b2b_fs[0];
      S = b2b_s[0];
      T = b2b_t[0];
      acc = cyc + 1;
      sc = done_cnt;
      push_exp(b2b_fs[0], b2b_s[0], b2b_t[0], acc);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         scramble();
         while (cyc < acc + 34) @(negedge clk);
         FS = b2b_fs[i];
         S = b2b_s[i];
         T = b2b_t[i];
         acc = acc + 35;
         push_exp(b2b_fs[i], b2b_s[i], b2b_t[i], acc);
      end
      @(negedge clk);
      start = 1'b0;
      scramble();
      wait_done(sc + 3, 200);

      // Randomized operations.
      for (int i = 0; i < 60; i++) begin
         fsr = OP_MULT + 5'($urandom_range(0, 3));
         sr = pick();
         tr = pick();
         if ((fsr == OP_DIV || fsr == OP_DIVU) && $urandom_range(0, 7) == 0) tr = 32'd0;
         issue(fsr, sr, tr);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      report(sbq.size() == 0, "drain", $sformatf("got %0d pending results, required 0", sbq.size()));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
